// File: rtl/logic_unit_pipe_if.sv
// Handshake bundle for logic_unit_pipe: operand/op input beat and result
// output beat, each with its own valid/ready pair.
// The "master" modport is the producer/consumer side (decoder + writeback);
// the "slave" modport is the logic unit itself.
interface logic_unit_pipe_if #(
  parameter int WIDTH = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [2:0]       in_sel;
  logic             in_acc;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_res;
  logic             out_zero;
  logic             out_ones;
  logic             out_par;

  modport master (
    output in_valid,
    output in_a,
    output in_b,
    output in_sel,
    output in_acc,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_res,
    input  out_zero,
    input  out_ones,
    input  out_par
  );

  modport slave (
    input  in_valid,
    input  in_a,
    input  in_b,
    input  in_sel,
    input  in_acc,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_res,
    output out_zero,
    output out_ones,
    output out_par
  );

endinterface

// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: two-stage pipelined bitwise logic unit with valid/ready
// flow control and registered zero/ones/parity flags.
//   S1 holds the accepted operands and op select.
//   S2 computes the op on S1 and registers result + flags (the output beat).
// Optional feature macro: LOGIC_UNIT_ACC_EN
//   defined   -> accumulator acc_q replaces operand a when the beat's acc bit
//                is set; acc_q takes every valid result as it enters S2.
//   undefined -> in_acc is ignored and no accumulator exists.
// Reset is synchronous, active-low (rst_n), and discards all in-flight beats.
module logic_unit_pipe #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  logic_unit_pipe_if.slave  bus
);

  typedef enum logic [2:0] {
    OP_NOT_A  = 3'b000,
    OP_NOT_B  = 3'b001,
    OP_AND    = 3'b010,
    OP_OR     = 3'b011,
    OP_XOR    = 3'b100,
    OP_XNOR   = 3'b101,
    OP_NAND   = 3'b110,
    OP_NOR    = 3'b111
  } op_e;

  // stage 1 registers
  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  op_e              s1_sel;

  // stage 2 (output) registers
  logic             out_valid_q;
  logic [WIDTH-1:0] out_res_q;
  logic             out_zero_q;
  logic             out_ones_q;
  logic             out_par_q;

  // flow control
  logic             stall2;
  logic             s1_load;
  logic             s2_load;

  // datapath between S1 and S2
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_res;
  logic             res_zero;
  logic             res_ones;
  logic             res_par;

`ifdef LOGIC_UNIT_ACC_EN
  logic             s1_acc;
  logic [WIDTH-1:0] acc_q;
`else
  // in_acc has no meaning without the accumulator
  logic             unused_in_acc;
  assign unused_in_acc = bus.in_acc;
`endif

  // The output register stalls only while it holds a beat nobody takes.
  // S1 may still load while S2 stalls as long as S1 itself is empty, which
  // gives the two-beat buffering depth.
  assign stall2   = out_valid_q && !bus.out_ready;
  assign s2_load  = !stall2;
  assign s1_load  = !(s1_valid && stall2);
  assign bus.in_ready = s1_load;

  // S1 valid bit: follows in_valid whenever S1 is allowed to load
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
    end else if (s1_load) begin
      s1_valid <= bus.in_valid;
    end
  end

  // S1 payload: captured only on an accepted beat, never needs reset
  always_ff @(posedge clk) begin
    if (s1_load && bus.in_valid) begin
      s1_a   <= bus.in_a;
      s1_b   <= bus.in_b;
      s1_sel <= op_e'(bus.in_sel);
`ifdef LOGIC_UNIT_ACC_EN
      s1_acc <= bus.in_acc;
`endif
    end
  end

  // operand a source: accumulator or the captured operand
  always_comb begin
    op_a = s1_a;
`ifdef LOGIC_UNIT_ACC_EN
    if (s1_acc) begin
      op_a = acc_q;
    end
`endif
  end

  // bitwise op on S1 contents, full width, no carries
  always_comb begin
    op_res = '0;
    unique case (s1_sel)
      OP_NOT_A: op_res = ~op_a;
      OP_NOT_B: op_res = ~s1_b;
      OP_AND:   op_res = op_a & s1_b;
      OP_OR:    op_res = op_a | s1_b;
      OP_XOR:   op_res = op_a ^ s1_b;
      OP_XNOR:  op_res = ~(op_a ^ s1_b);
      OP_NAND:  op_res = ~(op_a & s1_b);
      OP_NOR:   op_res = ~(op_a | s1_b);
      default:  op_res = '0;
    endcase
  end

  // flags derived from the same result that gets registered
  always_comb begin
    res_zero = 1'b0;
    res_ones = 1'b0;
    res_par  = 1'b0;
    res_zero = (op_res == '0);
    res_ones = &op_res;
    res_par  = ^op_res;
  end

  // S2: result, flags and out_valid advance together; payload only changes
  // on a valid beat so a stalled or idle output stays put
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_res_q   <= '0;
      out_zero_q  <= 1'b1;
      out_ones_q  <= 1'b0;
      out_par_q   <= 1'b0;
`ifdef LOGIC_UNIT_ACC_EN
      acc_q       <= '0;
`endif
    end else if (s2_load) begin
      out_valid_q <= s1_valid;
      if (s1_valid) begin
        out_res_q  <= op_res;
        out_zero_q <= res_zero;
        out_ones_q <= res_ones;
        out_par_q  <= res_par;
`ifdef LOGIC_UNIT_ACC_EN
        // beats enter S2 in order, so the next beat in S1 sees this result
        acc_q      <= op_res;
`endif
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_res   = out_res_q;
  assign bus.out_zero  = out_zero_q;
  assign bus.out_ones  = out_ones_q;
  assign bus.out_par   = out_par_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Scoreboard bench for logic_unit_pipe (WIDTH=8). Accepted beats push their
// expected result into a queue; an independent monitor pops on every output
// transfer and compares. Build with +define+LOGIC_UNIT_ACC_EN to cover the
// accumulator.
module tb_logic_unit_pipe;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] res;
    logic         zero;
    logic         ones;
    logic         par;
    int           tag;
    bit           lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic_unit_pipe_if #(.WIDTH(W)) bus ();

  logic_unit_pipe #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  exp_t         sb[$];
  int           checks   = 0;
  int           failures = 0;
  int           cyc      = 0;
  logic [W-1:0] ref_acc;
  bit           rnd_done;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // the op table, applied to plain values
  function automatic logic [W-1:0] model(input logic [2:0] sel, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    case (sel)
      3'd0:    return ~a;
      3'd1:    return ~b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return ~(a ^ b);
      3'd6:    return ~(a & b);
      default: return ~(a | b);
    endcase
  endfunction

  // present one beat, wait (bounded) for acceptance, record expectation
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] sel,
                      input logic acc, input bit directed, input logic [W-1:0] dres,
                      input bit lat);
    logic [W-1:0] opa;
    logic [W-1:0] r;
    exp_t         e;
    int           n;
    bit           ok;
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_sel   = sel;
    bus.in_acc   = acc;
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 200) begin
      @(negedge clk);
      if (bus.in_ready) ok = 1'b1;
      else n++;
    end
    if (!ok) begin
      check("accept_timeout", 32'(n), 32'd0);
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      return;
    end
`ifdef LOGIC_UNIT_ACC_EN
    opa = acc ? ref_acc : a;
`else
    opa = a;
`endif
    r = directed ? dres : model(sel, opa, b);
    ref_acc = r;
    e.res  = r;
    e.zero = (r == '0);
    e.ones = (r == '1);
    e.par  = ^r;
    e.tag  = cyc;
    e.lat  = lat;
    sb.push_back(e);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  // wait for every expected beat to come out, then realign to posedge+1
  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_left", 32'(sb.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    sb.delete();
    ref_acc = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // monitor: pops on each transfer, checks hold-stability under stall
  exp_t         mon_e;
  bit           prev_stall = 1'b0;
  logic [W-1:0] prev_res;
  logic [2:0]   prev_flags;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && bus.out_valid) begin
        check("stall_res_stable", 32'(bus.out_res), 32'(prev_res));
        check("stall_flags_stable", 32'({bus.out_zero, bus.out_ones, bus.out_par}),
              32'(prev_flags));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_out actual=%0h required=no_beat (t=%0t)", bus.out_res, $time);
        end else begin
          mon_e = sb.pop_front();
          check("res",  32'(bus.out_res),  32'(mon_e.res));
          check("zero", 32'(bus.out_zero), 32'(mon_e.zero));
          check("ones", 32'(bus.out_ones), 32'(mon_e.ones));
          check("par",  32'(bus.out_par),  32'(mon_e.par));
          if (mon_e.lat) check("latency", 32'(cyc - mon_e.tag), 32'd2);
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_res   = bus.out_res;
      prev_flags = {bus.out_zero, bus.out_ones, bus.out_par};
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  logic [W-1:0] sweep_exp [8];

  initial begin
    sweep_exp = '{8'h3C, 8'hA5, 8'h42, 8'hDB, 8'h99, 8'h66, 8'hBD, 8'h24};
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_sel    = '0;
    bus.in_acc    = 1'b0;
    bus.out_ready = 1'b1;
    ref_acc       = '0;
    rnd_done      = 1'b0;
    rst_n         = 1'b0;

    // reset held two cycles
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_res",   32'(bus.out_res),   32'h00);
    check("rst_out_zero",  32'(bus.out_zero),  32'd1);
    check("rst_out_ones",  32'(bus.out_ones),  32'd0);
    check("rst_out_par",   32'(bus.out_par),   32'd0);
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // op sweep, back to back, latency checked on each beat
    for (int s = 0; s < 8; s++) send(8'hC3, 8'h5A, 3'(s), 1'b0, 1'b1, sweep_exp[s], 1'b1);
    drain();

    // flag corners
    send(8'hFF, 8'hFF, 3'b100, 1'b0, 1'b1, 8'h00, 1'b1);
    send(8'hFF, 8'hFF, 3'b010, 1'b0, 1'b1, 8'hFF, 1'b1);
    drain();

    // backpressure: four beats against a blocked consumer
    bus.out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++)
          send(W'($urandom), W'($urandom), 3'($urandom_range(0, 7)), 1'b0, 1'b0, '0, 1'b0);
      end
      begin
        int n;
        n = 0;
        while (sb.size() < 2 && n < 50) begin
          @(posedge clk);
          #2;
          n++;
        end
        @(negedge clk);
        check("bp_accepted", 32'(sb.size()), 32'd2);
        check("bp_in_ready", 32'(bus.in_ready), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("bp_in_ready_held", 32'(bus.in_ready), 32'd0);
        check("bp_out_valid", 32'(bus.out_valid), 32'd1);
        check("bp_still_2", 32'(sb.size()), 32'd2);
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    drain();

    // reset with two beats in flight
    bus.out_ready = 1'b0;
    send(8'h12, 8'h34, 3'b011, 1'b0, 1'b0, '0, 1'b0);
    send(8'h56, 8'h78, 3'b100, 1'b0, 1'b0, '0, 1'b0);
    pulse_reset();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    end
    check("midrst_out_zero", 32'(bus.out_zero), 32'd1);
    @(posedge clk);
    #1;
    send(8'h0F, 8'hF0, 3'b011, 1'b0, 1'b1, 8'hFF, 1'b1);
    drain();

`ifdef LOGIC_UNIT_ACC_EN
    // accumulator chaining without bubbles, then cleared by reset
    send(8'h0F, 8'h00, 3'b011, 1'b0, 1'b1, 8'h0F, 1'b1);
    send(8'h00, 8'hF0, 3'b100, 1'b1, 1'b1, 8'hFF, 1'b1);
    drain();
    pulse_reset();
    send(8'h55, 8'hAA, 3'b011, 1'b1, 1'b1, 8'hAA, 1'b1);
    drain();
`endif

    // randomized traffic with gaps and random backpressure
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          send(W'($urandom), W'($urandom), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
               1'b0, '0, 1'b0);
          if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(posedge clk);
          #0;
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1 bus.out_ready = ($urandom_range(0, 3) != 0);
        end
        bus.out_ready = 1'b1;
      end
    join
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
